// File: rtl/chan_mux_scan_pkg.sv
// Shared definitions for the channel selector and its downstream serialiser.
// Mode encoding and index-width helper.
package chan_mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/chan_scan_ptr.sv
// Round-robin scan pointer with per-channel dwell counter.
// Advances only when the dwell has elapsed and the parent can take the sample.
module chan_scan_ptr
    import chan_mux_scan_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    parameter  int unsigned DWELL  = 4,
    localparam int unsigned SEL_W  = idx_w(NUM_CH),
    localparam int unsigned DW_W   = idx_w(DWELL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             adv_ok_i,
    input  logic             restart_i,
    output logic [SEL_W-1:0] ptr_o,
    output logic             dwell_done_o
);

    localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(NUM_CH - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             dwell_done_q, dwell_done_d;

    // Dwell saturates at its last value until the sample can be taken,
    // so a stalled output never causes a channel to be skipped.
    always_comb begin
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        if (restart_i) begin
            ptr_d   = '0;
            dwell_d = '0;
        end else if (en_i) begin
            if (dwell_q != DWELL_LAST) begin
                dwell_d = dwell_q + DW_W'(1);
            end else if (adv_ok_i) begin
                dwell_d = '0;
                ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + SEL_W'(1);
            end
        end
        dwell_done_d = (dwell_d == DWELL_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            dwell_q      <= '0;
            dwell_done_q <= (DWELL == 1);
        end else begin
            ptr_q        <= ptr_d;
            dwell_q      <= dwell_d;
            dwell_done_q <= dwell_done_d;
        end
    end

    assign ptr_o        = ptr_q;
    assign dwell_done_o = dwell_done_q;

endmodule

// File: rtl/chan_mux_scan.sv
// NUM_CH:1 channel selector with manual or round-robin scan selection,
// registered onto a valid/ready output stream.
module chan_mux_scan
    import chan_mux_scan_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    parameter  int unsigned DATA_W = 1,
    parameter  int unsigned DWELL  = 4,
    localparam int unsigned SEL_W  = idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    logic              mode_q;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_err_q, sel_err_d;

    logic              scan_c;
    logic              restart_c;
    logic              slot_free_c;
    logic              sel_ok_c;
    logic              capture_c;
    logic [SEL_W-1:0]  cur_ch_c;
    logic [DATA_W-1:0] cur_data_c;
    logic [SEL_W-1:0]  ptr;
    logic              dwell_done;

    chan_scan_ptr #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL)
    ) u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en && scan_c),
        .adv_ok_i     (slot_free_c),
        .restart_i    (restart_c),
        .ptr_o        (ptr),
        .dwell_done_o (dwell_done)
    );

    // Selection and capture decision.
    always_comb begin
        scan_c      = (mode == MODE_SCAN);
        restart_c   = scan_c && (mode_q == MODE_MANUAL);
        slot_free_c = !out_valid_q || out_ready;
        sel_ok_c    = (32'(sel) < NUM_CH);
        cur_ch_c    = scan_c ? ptr : sel;
        if (scan_c) begin
            capture_c = en && slot_free_c && !restart_c && dwell_done;
        end else begin
            capture_c = en && slot_free_c && sel_ok_c;
        end
    end

    // Channel mux; out-of-range indices fall through to zero and are never captured.
    always_comb begin
        cur_data_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cur_ch_c == SEL_W'(k)) begin
                cur_data_c = ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output register next state: load on capture, drop valid on an idle accept.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sel_err_d   = !scan_c && en && !sel_ok_c;
        if (capture_c) begin
            out_data_d  = cur_data_c;
            out_ch_d    = cur_ch_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_MANUAL;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            mode_q      <= mode;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Self-checking bench for chan_mux_scan: a 4-channel/DWELL=3 instance against a
// behavioural model, plus a 3-channel/DWELL=1 instance for range and wrap cases.
`timescale 1ns/1ps
module tb_chan_mux_scan;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DWELL  = 3;
    localparam int SEL_W  = 2;
    localparam int NCH3   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic                     en, mode, out_ready, out_valid, sel_err;
    logic [SEL_W-1:0]         sel, out_ch;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]        out_data;

    logic                   en3, mode3, ready3, valid3, err3;
    logic [SEL_W-1:0]       sel3, ch3;
    logic [NCH3*DATA_W-1:0] data3_in;
    logic [DATA_W-1:0]      data3_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [1+1+SEL_W+DATA_W-1:0] got, exp;

    always #5 clk = ~clk;

    chan_mux_scan #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .ch_data(ch_data),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    chan_mux_scan #(.NUM_CH(NCH3), .DATA_W(DATA_W), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel(sel3), .ch_data(data3_in),
        .out_data(data3_out), .out_ch(ch3), .out_valid(valid3),
        .out_ready(ready3), .sel_err(err3)
    );

    function automatic logic [7:0] base_byte(input int k);
        return 8'(170 + 17 * k);
    endfunction

    // Behavioural reference for the 4-channel instance, in plain integer terms.
    logic       m_valid, m_err, m_mode_q;
    logic [7:0] m_data;
    int         m_ch, m_ptr, m_dwell, m_cur;
    bit         m_free, m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_err <= 0; m_mode_q <= 0; m_data <= 0;
            m_ch <= 0; m_ptr <= 0; m_dwell <= 0;
        end else begin
            m_free = !m_valid || out_ready;
            m_take = 0;
            m_cur  = 0;
            m_mode_q <= mode;
            m_err    <= !mode && en && (int'(sel) >= NUM_CH);
            if (mode && !m_mode_q) begin
                m_ptr   <= 0;
                m_dwell <= 0;
            end else if (mode) begin
                if (en) begin
                    if (m_dwell < DWELL - 1) m_dwell <= m_dwell + 1;
                    else if (m_free) begin
                        m_take = 1;
                        m_cur  = m_ptr;
                        m_ptr  <= (m_ptr + 1) % NUM_CH;
                        m_dwell <= 0;
                    end
                end
            end else if (en && m_free && int'(sel) < NUM_CH) begin
                m_take = 1;
                m_cur  = int'(sel);
            end
            if (m_take) begin
                m_valid <= 1;
                m_data  <= ch_data[m_cur*DATA_W +: DATA_W];
                m_ch    <= m_cur;
            end else if (out_ready) begin
                m_valid <= 0;
            end
        end
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({out_valid, sel_err, out_ch, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_main: got v=%b e=%b ch=%0d d=%h, want all zero", out_valid, sel_err, out_ch, out_data);
        end
        n_cmp++;
        if ({valid3, err3, ch3, data3_out} !== '0) begin
            n_err++;
            $display("FAIL reset_ch3: got v=%b e=%b ch=%0d d=%h, want all zero", valid3, err3, ch3, data3_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual_step();
        mode = 0; en = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            sel = SEL_W'(i);
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b1, SEL_W'(i), base_byte(i)}) begin
                n_err++;
                $display("FAIL manual_step[%0d]: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                         i, out_valid, out_ch, out_data, i, base_byte(i));
            end
        end
    endtask

    task automatic test_manual_hold();
        sel = 2; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        ch_data[2*DATA_W +: DATA_W] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hCC}) begin
                n_err++;
                $display("FAIL manual_hold[%0d]: got v=%b ch=%0d d=%h, want v=1 ch=2 d=cc",
                         i, out_valid, out_ch, out_data);
            end
        end
        out_ready = 1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'h55}) begin
            n_err++;
            $display("FAIL manual_release: got v=%b ch=%0d d=%h, want v=1 ch=2 d=55", out_valid, out_ch, out_data);
        end
        en = 0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_data} !== {1'b0, 8'h55}) begin
            n_err++;
            $display("FAIL manual_idle: got v=%b d=%h, want v=0 d=55 held", out_valid, out_data);
        end
        ch_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    endtask

    task automatic test_scan_rr();
        int q_cyc[$];
        int q_ch[$];
        logic [7:0] q_dat[$];
        mode = 1; en = 1; out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            got = {out_valid, sel_err, out_ch, out_data};
            exp = {m_valid, m_err, SEL_W'(m_ch), m_data};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL scan_rr_cyc%0d: got %h want %h", i, got, exp);
            end
            if (out_valid) begin
                q_cyc.push_back(i); q_ch.push_back(int'(out_ch)); q_dat.push_back(out_data);
            end
        end
        n_cmp++;
        if (q_ch.size() != 5) begin
            n_err++;
            $display("FAIL scan_rr_count: got %0d samples, want 5", q_ch.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (q_ch[k] != k % NUM_CH || q_dat[k] !== base_byte(k % NUM_CH) ||
                    (k > 0 && q_cyc[k] - q_cyc[k-1] != DWELL)) begin
                    n_err++;
                    $display("FAIL scan_rr_sample%0d: got ch=%0d d=%h at cyc %0d, want ch=%0d d=%h every %0d cycles",
                             k, q_ch[k], q_dat[k], q_cyc[k], k % NUM_CH, base_byte(k % NUM_CH), DWELL);
                end
            end
        end
    endtask

    task automatic test_scan_stall();
        bit seen = 0;
        mode = 0; en = 0; out_ready = 1;
        @(negedge clk);
        mode = 1; en = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        n_cmp++;
        if (!seen || out_ch !== 2'd0 || out_data !== 8'hAA) begin
            n_err++;
            $display("FAIL stall_first: got seen=%b ch=%0d d=%h, want ch=0 d=aa", seen, out_ch, out_data);
        end
        out_ready = 0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hAA} ||
            dut.u_ptr.ptr_q !== 2'd1 || dut.u_ptr.dwell_q !== 2'd2) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b ch=%0d d=%h ptr=%0d dwell=%0d, want v=1 ch=0 d=aa ptr=1 dwell=2",
                     out_valid, out_ch, out_data, dut.u_ptr.ptr_q, dut.u_ptr.dwell_q);
        end
        out_ready = 1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'hBB}) begin
            n_err++;
            $display("FAIL stall_release: got v=%b ch=%0d d=%h, want v=1 ch=1 d=bb", out_valid, out_ch, out_data);
        end
        mode = 0; en = 0;
        @(negedge clk);
    endtask

    task automatic test_sel_err3();
        data3_in = {8'h33, 8'h22, 8'h11};
        mode3 = 0; en3 = 1; sel3 = 3; ready3 = 1;
        @(negedge clk);
        n_cmp++;
        if ({err3, valid3} !== 2'b10) begin
            n_err++;
            $display("FAIL selerr_pulse: got err=%b v=%b, want err=1 v=0", err3, valid3);
        end
        en3 = 0;
        @(negedge clk);
        n_cmp++;
        if ({err3, valid3} !== 2'b00) begin
            n_err++;
            $display("FAIL selerr_clear: got err=%b v=%b, want err=0 v=0", err3, valid3);
        end
        en3 = 1; sel3 = 1;
        @(negedge clk);
        n_cmp++;
        if ({valid3, err3, ch3, data3_out} !== {1'b1, 1'b0, 2'd1, 8'h22}) begin
            n_err++;
            $display("FAIL ch3_manual: got v=%b e=%b ch=%0d d=%h, want v=1 e=0 ch=1 d=22", valid3, err3, ch3, data3_out);
        end
        en3 = 0;
        @(negedge clk);
    endtask

    task automatic test_scan_wrap3();
        logic [7:0] b;
        mode3 = 1; en3 = 1; ready3 = 1; sel3 = 3;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            b = 8'(17 * (((i - 2) % NCH3) + 1));
            n_cmp++;
            if (i == 1 ? ({valid3, err3} !== 2'b00)
                       : ({valid3, err3, ch3, data3_out} !== {1'b1, 1'b0, SEL_W'((i - 2) % NCH3), b})) begin
                n_err++;
                $display("FAIL wrap3_cyc%0d: got v=%b e=%b ch=%0d d=%h, want ch=%0d d=%h (none on cyc 1)",
                         i, valid3, err3, ch3, data3_out, (i - 2) % NCH3, b);
            end
        end
        mode3 = 0; en3 = 0;
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int first = 0;
        mode = 1; en = 1; out_ready = 1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid && (out_ch == 2'd1);
        end
        out_ready = 0;
        n_cmp++;
        if (!seen || dut.u_ptr.ptr_q !== 2'd2) begin
            n_err++;
            $display("FAIL midrst_setup: got seen=%b ptr=%0d, want seen=1 ptr=2", seen, dut.u_ptr.ptr_q);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sel_err, out_ch, out_data} !== '0 || dut.u_ptr.ptr_q !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b e=%b ch=%0d d=%h ptr=%0d, want all zero",
                     out_valid, sel_err, out_ch, out_data, dut.u_ptr.ptr_q);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            @(negedge clk);
            if (out_valid) first = i;
        end
        n_cmp++;
        if (first != DWELL + 1 || out_ch !== 2'd0 || out_data !== 8'hAA) begin
            n_err++;
            $display("FAIL midrst_first: got edge=%0d ch=%0d d=%h, want edge=%0d ch=0 d=aa",
                     first, out_ch, out_data, DWELL + 1);
        end
    endtask

    task automatic test_rand();
        logic       pv, pr;
        logic [9:0] pd;
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel       = SEL_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            ch_data   = $urandom;
            pv = out_valid; pr = out_ready; pd = {out_ch, out_data};
            @(negedge clk);
            got = {out_valid, sel_err, out_ch, out_data};
            exp = {m_valid, m_err, SEL_W'(m_ch), m_data};
            n_cmp++;
            if (got !== exp || (pv && !pr && (!out_valid || {out_ch, out_data} !== pd))) begin
                n_err++;
                $display("FAIL rand_cyc%0d: got %h want %h (held=%b prev %h)", i, got, exp, pv && !pr, pd);
            end
        end
    endtask

    initial begin
        en = 0; mode = 0; sel = 0; out_ready = 0;
        ch_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        en3 = 0; mode3 = 0; sel3 = 0; ready3 = 0; data3_in = '0;
        test_reset();
        test_manual_step();
        test_manual_hold();
        test_scan_rr();
        test_scan_stall();
        test_sel_err3();
        test_scan_wrap3();
        test_reset_mid();
        test_rand();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
